// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring DIV/DIVU sequencer, one quotient bit/cycle.
// Optional DIV_ZERO_FAST_EN: divide-by-zero bypasses iteration to DONE.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             stall_ext,
  output logic             div_stall,
  output logic             div_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             tpos;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             accept;
  logic             last;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    a_mag  = (div_signed & opa[WIDTH-1]) ? -opa : opa;
    b_mag  = (div_signed & opb[WIDTH-1]) ? -opb : opb;
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, dvsr};
    tpos   = ~trial[WIDTH+1];
    rem_nx = tpos ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], tpos};
    accept = (state == IDLE) & div_start & ~cancel;
    last   = (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic with stall/valid outputs.
  always_comb begin
    state_n   = state;
    div_stall = 1'b0;
    div_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          div_stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (opb == '0) state_n = DONE;
          else           state_n = BUSY;
`else
          state_n = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cancel) begin
          state_n = IDLE;
        end else begin
          div_stall = 1'b1;
          if (last) state_n = DONE;
        end
      end
      DONE: begin
        if (cancel) begin
          state_n = IDLE;
        end else begin
          div_valid = 1'b1;
          if (!stall_ext) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= a_mag;
      dvsr  <= b_mag;
      q_neg <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
      r_neg <= div_signed & opa[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
      if (opb == '0) begin
        hi_o <= opa;
        lo_o <= '1;
      end
`endif
    end else if (state == BUSY && !cancel) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        lo_o <= q_neg ? -quo_nx : quo_nx;
        hi_o <= r_neg ? -rem_nx : rem_nx;
      end
    end
  end

endmodule
